// File: rtl/dtree_vote_collector.sv
// dtree_vote_collector
//
// Majority-vote smoother behind the pendigits decision-tree classifier.
// Labels are counted per class over a window of WINDOW accepted samples, or
// over a shorter window cut off by flush. An arg-max scan then runs one class
// per cycle, and the winning class is held on a valid/ready output.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     label present on in_class
//   in_class     classifier label (values >= NUM_CLASSES count as invalid)
//   in_ready     collector can accept a label (only while accumulating)
//   flush        single-cycle pulse; vote on a partial window
//   out_valid    result held on out_* ports
//   out_ready    consumer takes the result
//   out_class    majority class, 4'hF when no valid label was counted
//   out_count    votes for out_class
//   out_invalid  labels >= NUM_CLASSES in the window
module dtree_vote_collector #(
  parameter int unsigned WINDOW      = 8,
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       in_class,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_class,
  output logic [CNT_W-1:0] out_count,
  output logic [CNT_W-1:0] out_invalid
);

  typedef enum logic [1:0] {StAccum, StScan, StDone} state_e;

  localparam logic [3:0]       LastIdx  = 4'(NUM_CLASSES - 1);
  localparam logic [3:0]       NumCls   = 4'(NUM_CLASSES);
  localparam logic [CNT_W-1:0] WinLimit = CNT_W'(WINDOW);
  localparam logic [3:0]       NoClass  = 4'hF;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [NUM_CLASSES];
  logic [CNT_W-1:0] cnt_d [NUM_CLASSES];
  logic [CNT_W-1:0] inv_cnt_q, inv_cnt_d;
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
  logic [3:0]       best_class_q, best_class_d;

  logic             accept;
  logic             label_ok;
  logic [CNT_W-1:0] cur_cnt;

  assign in_ready    = (state_q == StAccum);
  assign accept      = in_valid && in_ready;
  assign label_ok    = (in_class < NumCls);

  // best_* double as the output registers; their reset values are the
  // required idle output values.
  assign out_valid   = (state_q == StDone);
  assign out_class   = best_class_q;
  assign out_count   = best_cnt_q;
  assign out_invalid = inv_cnt_q;

  // Counter selected by the scan index, built as a mux so any NUM_CLASSES works.
  always_comb begin
    cur_cnt = '0;
    for (int i = 0; i < int'(NUM_CLASSES); i++) begin
      if (idx_q == 4'(i)) cur_cnt = cnt_q[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    inv_cnt_d    = inv_cnt_q;
    win_cnt_d    = win_cnt_q;
    idx_d        = idx_q;
    best_cnt_d   = best_cnt_q;
    best_class_d = best_class_q;

    unique case (state_q)
      StAccum: begin
        if (accept) begin
          if (label_ok) begin
            for (int i = 0; i < int'(NUM_CLASSES); i++) begin
              if (in_class == 4'(i)) cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end else begin
            inv_cnt_d = inv_cnt_q + 1'b1;
          end
          win_cnt_d = win_cnt_q + 1'b1;
        end
        // A flush on an empty window with no accept is a no-op.
        if ((accept && (win_cnt_d == WinLimit)) ||
            (flush && ((win_cnt_q != '0) || accept))) begin
          state_d      = StScan;
          idx_d        = '0;
          best_cnt_d   = '0;
          best_class_d = NoClass;
        end
      end
      StScan: begin
        // Strict compare: lowest index wins ties, empty classes never win.
        if (cur_cnt > best_cnt_q) begin
          best_cnt_d   = cur_cnt;
          best_class_d = idx_q;
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == LastIdx) state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          for (int i = 0; i < int'(NUM_CLASSES); i++) cnt_d[i] = '0;
          inv_cnt_d    = '0;
          win_cnt_d    = '0;
          best_cnt_d   = '0;
          best_class_d = NoClass;
          state_d      = StAccum;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StAccum;
      for (int i = 0; i < int'(NUM_CLASSES); i++) cnt_q[i] <= '0;
      inv_cnt_q    <= '0;
      win_cnt_q    <= '0;
      idx_q        <= '0;
      best_cnt_q   <= '0;
      best_class_q <= NoClass;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      inv_cnt_q    <= inv_cnt_d;
      win_cnt_q    <= win_cnt_d;
      idx_q        <= idx_d;
      best_cnt_q   <= best_cnt_d;
      best_class_q <= best_class_d;
    end
  end

endmodule

// File: tb/tb_dtree_vote_collector.sv
module tb_dtree_vote_collector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_class;
  logic       in_ready;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_class;
  logic [3:0] out_count;
  logic [3:0] out_invalid;

  int vectors = 0;
  int miscompares = 0;

  dtree_vote_collector #(
    .WINDOW     (8),
    .NUM_CLASSES(10),
    .CNT_W      (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_class   (in_class),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_class  (out_class),
    .out_count  (out_count),
    .out_invalid(out_invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] lbl);
    in_valid = 1'b1;
    in_class = lbl;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_class = 4'h0;
  endtask

  // Counts edges until out_valid is seen, bounded at 50.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic check_result(input string tag, input logic [3:0] cls, input logic [3:0] cnt,
                              input logic [3:0] inv);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_class"}, 32'(out_class), 32'(cls));
    check({tag, "_count"}, 32'(out_count), 32'(cnt));
    check({tag, "_invalid"}, 32'(out_invalid), 32'(inv));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int seen;
    logic [3:0] win1 [8];
    logic [3:0] win2 [8];
    logic [3:0] win3 [8];
    win1 = '{4'd3, 4'd3, 4'd3, 4'd5, 4'd5, 4'd1, 4'd3, 4'd7};
    win2 = '{4'd2, 4'd2, 4'd6, 4'd6, 4'd2, 4'd6, 4'd9, 4'd9};
    win3 = '{4'd7, 4'd7, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_class  = 4'h0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_class", 32'(out_class), 32'hF);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_invalid", 32'(out_invalid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Full window, out_ready high.
    for (int i = 0; i < 8; i++) send(win1[i]);
    check("win_in_ready_low", 32'(in_ready), 32'd0);
    wait_valid(n);
    check("win_latency", 32'(n), 32'd10);
    check_result("win", 4'd3, 4'd4, 4'd0);
    @(posedge clk);
    #1;
    check("win_valid_one_cycle", 32'(out_valid), 32'd0);
    check("win_in_ready_back", 32'(in_ready), 32'd1);

    // Tie-break, then backpressure with a stray label held on the input.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(win2[i]);
    wait_valid(n);
    check("tie_latency", 32'(n), 32'd10);
    check_result("tie", 4'd2, 4'd3, 4'd0);
    in_valid = 1'b1;
    in_class = 4'd8;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold", {out_valid, out_class, out_count, out_invalid}, {1'b1, 4'd2, 4'd3, 4'd0});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);

    // All invalid; also shows label 8 from backpressure was never counted.
    for (int i = 0; i < 8; i++) send(4'hF);
    wait_valid(n);
    check_result("allinv", 4'hF, 4'd0, 4'd8);
    @(posedge clk);
    #1;

    // Partial window via flush.
    send(4'd4);
    send(4'd4);
    send(4'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    wait_valid(n);
    check("flush_latency", 32'(n), 32'd10);
    check_result("flush", 4'd4, 4'd2, 4'd0);
    @(posedge clk);
    #1;

    // Flush with empty window is ignored.
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("eflush_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("eflush_no_valid", 32'(seen), 32'd0);

    // Flush together with an accept.
    in_valid = 1'b1;
    in_class = 4'd5;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check("aflush_in_ready", 32'(in_ready), 32'd0);
    wait_valid(n);
    check("aflush_latency", 32'(n), 32'd10);
    check_result("aflush", 4'd5, 4'd1, 4'd0);
    @(posedge clk);
    #1;

    // Reset three cycles into SCAN.
    for (int i = 0; i < 8; i++) send(4'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    check("mid_scan_busy", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_out_class", 32'(out_class), 32'hF);
    check("mrst_out_count", 32'(out_count), 32'd0);
    check("mrst_out_invalid", 32'(out_invalid), 32'd0);
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("mrst_no_result", 32'(seen), 32'd0);
    for (int i = 0; i < 8; i++) send(win3[i]);
    wait_valid(n);
    check("post_rst_latency", 32'(n), 32'd10);
    check_result("post_rst", 4'd7, 4'd3, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
